// File: rtl/stream_scheduler_if.sv
// stream_scheduler_if: fin memory write port of the streaming scheduler.
// master = scheduler, slave = memory.
interface stream_scheduler_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 8
);
    logic                     fin_we;
    logic [ADDRESS_WIDTH-1:0] fin_wr_addr;
    logic [3:0]               fin_wr_dir;
    logic [DATA_WIDTH-1:0]    fin_wr_data;
    logic                     fin_wr_ready;

    modport master (
        output fin_we,
        output fin_wr_addr,
        output fin_wr_dir,
        output fin_wr_data,
        input  fin_wr_ready
    );

    modport slave (
        input  fin_we,
        input  fin_wr_addr,
        input  fin_wr_dir,
        input  fin_wr_data,
        output fin_wr_ready
    );
endinterface

// File: rtl/stream_scheduler.sv
// stream_scheduler: streams nine post-collision values of one LBM node.
// Define STREAM_SKIP_EN to let invalid directions consume zero cycles.
module stream_scheduler #(
    parameter int DATA_WIDTH     = 64,
    parameter int GRID_DIM       = 256,
    parameter int ADDRESS_WIDTH  = $clog2(GRID_DIM),
    parameter int ADDRESS_WIDTH2 = $clog2(GRID_DIM) + 1,
    parameter int NDIR           = 9
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           start,
    input  logic [NDIR*ADDRESS_WIDTH2-1:0] stream_addr,
    input  logic [NDIR*DATA_WIDTH-1:0]     fout,
    stream_scheduler_if.master             fin,
    output logic                           busy,
    output logic                           done,
    output logic [3:0]                     wr_count,
    output logic                           oob_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    typedef logic [ADDRESS_WIDTH2-1:0] addr_arr_t [NDIR];
    typedef logic [DATA_WIDTH-1:0]     data_arr_t [NDIR];

    localparam logic [3:0] LAST_DIR = 4'(NDIR - 1);

    state_t     state_q, state_d;
    logic [3:0] dir_q, dir_d;
    logic [3:0] wr_count_q, wr_count_d;
    logic       oob_q, oob_d;
    addr_arr_t  snap_addr_q, snap_addr_d, in_addr;
    data_arr_t  snap_data_q, snap_data_d, in_data;
    logic       cur_valid, accept, advance;
`ifdef STREAM_SKIP_EN
    logic [4:0] nxt;
`endif

    function automatic logic addr_ok(input logic [ADDRESS_WIDTH2-1:0] a);
        return (a != '1) && (a < ADDRESS_WIDTH2'(GRID_DIM));
    endfunction

    function automatic logic any_oob(input addr_arr_t a);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NDIR; k++)
            r = r | ((a[k] != '1) && !addr_ok(a[k]));
        return r;
    endfunction

`ifdef STREAM_SKIP_EN
    // {found, index} of the lowest valid direction at or above 'from'
    function automatic logic [4:0] next_valid(input addr_arr_t a,
                                              input int from);
        logic [4:0] r;
        r = '0;
        for (int k = NDIR - 1; k >= 0; k--)
            if (k >= from && addr_ok(a[k]))
                r = {1'b1, 4'(k)};
        return r;
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        wr_count_d  = wr_count_q;
        oob_d       = oob_q;
        snap_addr_d = snap_addr_q;
        snap_data_d = snap_data_q;
`ifdef STREAM_SKIP_EN
        nxt         = '0;
`endif
        for (int k = 0; k < NDIR; k++) begin
            in_addr[k] = stream_addr[k*ADDRESS_WIDTH2 +: ADDRESS_WIDTH2];
            in_data[k] = fout[k*DATA_WIDTH +: DATA_WIDTH];
        end

        cur_valid = addr_ok(snap_addr_q[dir_q]);
        accept    = (state_q == ISSUE) && cur_valid && fin.fin_wr_ready;
        advance   = (state_q == ISSUE) && (!cur_valid || fin.fin_wr_ready);

        if (state_q != IDLE)
            oob_d = oob_q | any_oob(snap_addr_q);
        if (accept)
            wr_count_d = wr_count_q + 4'd1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_addr_d = in_addr;
                    snap_data_d = in_data;
                    wr_count_d  = '0;
                    oob_d       = 1'b0;
`ifdef STREAM_SKIP_EN
                    nxt     = next_valid(in_addr, 0);
                    dir_d   = nxt[3:0];
                    state_d = nxt[4] ? ISSUE : DONE;
`else
                    dir_d   = '0;
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                if (advance) begin
`ifdef STREAM_SKIP_EN
                    nxt = next_valid(snap_addr_q, int'(dir_q) + 1);
                    if (nxt[4])
                        dir_d = nxt[3:0];
                    else
                        state_d = DONE;
`else
                    if (dir_q == LAST_DIR)
                        state_d = DONE;
                    else
                        dir_d = dir_q + 4'd1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                dir_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            dir_q       <= '0;
            wr_count_q  <= '0;
            oob_q       <= 1'b0;
            snap_addr_q <= '{default: '0};
            snap_data_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            wr_count_q  <= wr_count_d;
            oob_q       <= oob_d;
            snap_addr_q <= snap_addr_d;
            snap_data_q <= snap_data_d;
        end
    end

    assign fin.fin_we      = (state_q == ISSUE) && cur_valid;
    assign fin.fin_wr_addr = snap_addr_q[dir_q][ADDRESS_WIDTH-1:0];
    assign fin.fin_wr_dir  = dir_q;
    assign fin.fin_wr_data = snap_data_q[dir_q];
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign wr_count        = wr_count_q;
    assign oob_err         = oob_q;
endmodule
